// File: rtl/pci_simple_target.sv
// PCI memory target with a 2**DEPTH_LOG2-word register file behind a single decode window.
// Optional macro PCI_TGT_WAIT_STATE_EN inserts one wait state before the first data phase.
module pci_simple_target #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ad_in,
  output logic [31:0] ad_out,
  output logic        ad_oe,
  input  logic [3:0]  cbe_n,
  input  logic        frame_n,
  input  logic        irdy_n,
  output logic        devsel_n,
  output logic        trdy_n,
  output logic        stop_n
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] IDX_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_TURN, S_WDATA, S_RDATA, S_DISC, S_BACKOFF
  } state_e;

  state_e                state_q, state_d;
  logic                  frame_prev_q;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic                  is_wr_q, is_wr_d;
  logic [31:0]           mem_q [DEPTH];

  logic addr_phase, hit, cmd_rd, cmd_wr, at_end, wr_xfer;

  assign cmd_rd     = (cbe_n == 4'b0110);
  assign cmd_wr     = (cbe_n == 4'b0111);
  assign addr_phase = (state_q == S_IDLE) && !frame_n && frame_prev_q;
  assign hit        = (ad_in[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2]) &&
                      (ad_in[1:0] == 2'b00) && (cmd_rd || cmd_wr);
  assign at_end     = (idx_q == IDX_MAX);
  assign wr_xfer    = (state_q == S_WDATA) && !irdy_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      frame_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      frame_prev_q <= frame_n;
    end
  end

  // Burst index, command and storage are never reset; only the control path is.
  always_ff @(posedge clk) begin
    idx_q   <= idx_d;
    is_wr_q <= is_wr_d;
    if (wr_xfer) begin
      for (int b = 0; b < 4; b++) begin
        if (!cbe_n[b]) mem_q[idx_q][8*b +: 8] <= ad_in[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    is_wr_d = is_wr_q;
    case (state_q)
      S_IDLE: begin
        if (addr_phase && hit) begin
          idx_d   = ad_in[DEPTH_LOG2+1:2];
          is_wr_d = cmd_wr;
`ifdef PCI_TGT_WAIT_STATE_EN
          state_d = cmd_wr ? S_WAIT : S_TURN;
`else
          state_d = cmd_wr ? S_WDATA : S_TURN;
`endif
        end
      end
      S_TURN: begin
        if (frame_n && irdy_n) state_d = S_BACKOFF;
`ifdef PCI_TGT_WAIT_STATE_EN
        else                   state_d = S_WAIT;
`else
        else                   state_d = S_RDATA;
`endif
      end
      S_WAIT: begin
        if (frame_n && irdy_n) state_d = S_BACKOFF;
        else                   state_d = is_wr_q ? S_WDATA : S_RDATA;
      end
      S_WDATA, S_RDATA: begin
        // The index saturates at the window end; the disconnect stops the burst there.
        if (!irdy_n) begin
          if (!at_end)      idx_d   = idx_q + 1'b1;
          if (frame_n)      state_d = S_BACKOFF;
          else if (at_end)  state_d = S_DISC;
        end else if (frame_n) begin
          state_d = S_BACKOFF;
        end
      end
      S_DISC:    if (frame_n) state_d = S_BACKOFF;
      S_BACKOFF: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    devsel_n = 1'b1;
    trdy_n   = 1'b1;
    stop_n   = 1'b1;
    ad_oe    = 1'b0;
    ad_out   = '0;
    case (state_q)
      S_TURN: devsel_n = 1'b0;
      S_WAIT: begin
        devsel_n = 1'b0;
        ad_oe    = !is_wr_q;
        ad_out   = is_wr_q ? '0 : mem_q[idx_q];
      end
      S_WDATA: begin
        devsel_n = 1'b0;
        trdy_n   = 1'b0;
        stop_n   = !at_end;
      end
      S_RDATA: begin
        devsel_n = 1'b0;
        trdy_n   = 1'b0;
        stop_n   = !at_end;
        ad_oe    = 1'b1;
        ad_out   = mem_q[idx_q];
      end
      S_DISC: begin
        devsel_n = 1'b0;
        stop_n   = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pci_simple_target.sv
// Bench for pci_simple_target: a bus-master model drives PCI cycles and a word-array
// reference decides claim, handshake timing, disconnects and read data.
module tb_pci_simple_target;

  localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef PCI_TGT_WAIT_STATE_EN
  localparam int WS = 1;
`else
  localparam int WS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ad_in = '0;
  logic [31:0] ad_out;
  logic        ad_oe;
  logic [3:0]  cbe_n = 4'hF;
  logic        frame_n = 1'b1;
  logic        irdy_n = 1'b1;
  logic        devsel_n, trdy_n, stop_n;

  int tests = 0;
  int fails = 0;

  logic [31:0] ref_mem [16];
  logic [31:0] dat [16];
  logic [3:0]  ben [16];

  always #5 clk = ~clk;

  pci_simple_target dut (
    .clk(clk), .rst(rst), .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe),
    .cbe_n(cbe_n), .frame_n(frame_n), .irdy_n(irdy_n),
    .devsel_n(devsel_n), .trdy_n(trdy_n), .stop_n(stop_n)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic dv, input logic tr,
                         input logic st, input logic oe);
    chk({tag, ".devsel_n"}, 32'(devsel_n), 32'(dv));
    chk({tag, ".trdy_n"},   32'(trdy_n),   32'(tr));
    chk({tag, ".stop_n"},   32'(stop_n),   32'(st));
    chk({tag, ".ad_oe"},    32'(ad_oe),    32'(oe));
  endtask

  task automatic fill_rand(input bit be_zero);
    for (int i = 0; i < 16; i++) begin
      dat[i] = $urandom;
      ben[i] = be_zero ? 4'h0 : 4'($urandom);
    end
  endtask

  // One master transaction; outputs are checked at each falling edge, i.e. the values
  // the target presents for the next rising edge.
  task automatic xact(input string tag, input logic [31:0] addr, input logic [3:0] cmd,
                      input int nph, input int wpct);
    bit hit, rd, done, disc, ready, fr, ir;
    int widx, ph, c, lat;
    rd   = (cmd == 4'b0110);
    hit  = ((addr >> 6) == (BASE >> 6)) && (addr[1:0] == 2'b00) &&
           (cmd == 4'b0110 || cmd == 4'b0111);
    widx = int'(addr[5:2]);
    @(negedge clk);
    frame_n = 1'b0; irdy_n = 1'b1; ad_in = addr; cbe_n = cmd;
    if (!hit) begin
      @(negedge clk);
      frame_n = 1'b1; irdy_n = 1'b0; ad_in = $urandom; cbe_n = 4'h0;
      for (int k = 0; k < 3; k++) begin
        chk_bus({tag, ".nohit"}, 1, 1, 1, 0);
        @(negedge clk);
      end
      irdy_n = 1'b1;
      return;
    end
    lat = (rd ? 2 : 1) + WS;
    c = 0; ph = 0; done = 0; disc = 0; fr = 0;
    while (!done && c < 64) begin
      @(negedge clk);
      c++;
      if (disc) begin
        chk_bus({tag, ".disc"}, 0, 1, 0, 0);
        frame_n = 1'b1; irdy_n = 1'b1;
        done = 1;
      end else begin
        ready = (c >= lat);
        chk_bus({tag, ".data"}, 0, !ready, !(ready && widx == 15), rd && c >= 2);
        if (rd && ready) chk({tag, ".ad_out"}, ad_out, ref_mem[widx]);
        ir = fr ? 1'b0 : ($urandom_range(99) < wpct);
        fr = fr || (!ir && ph == nph - 1);
        frame_n = fr; irdy_n = ir;
        if (rd) begin
          ad_in = $urandom; cbe_n = 4'($urandom);
        end else begin
          ad_in = dat[ph]; cbe_n = ben[ph];
        end
        if (ready && !ir) begin
          if (!rd)
            for (int b = 0; b < 4; b++)
              if (!ben[ph][b]) ref_mem[widx][8*b +: 8] = dat[ph][8*b +: 8];
          ph++;
          if (fr)              done = 1;
          else if (widx == 15) disc = 1;
          else                 widx++;
        end
      end
    end
    if (!done) chk({tag, ".timeout"}, 32'd1, 32'd0);
    @(negedge clk);
    chk_bus({tag, ".backoff"}, 1, 1, 1, 0);
    frame_n = 1'b1; irdy_n = 1'b1; ad_in = '0; cbe_n = 4'hF;
  endtask

  initial begin
    // Reset and idle bus
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_bus("reset_idle", 1, 1, 1, 0);
      chk("reset_idle.ad_out", ad_out, 32'h0);
    end

    // Fill the whole window in one burst that ends exactly at the last word
    fill_rand(1);
    xact("init_wr", BASE, 4'b0111, 16, 0);
    xact("init_rd", BASE, 4'b0110, 16, 30);

    // Two-phase write then read-back at word 2
    dat[0] = 32'hA5A5_0001; dat[1] = 32'hA5A5_0002; ben[0] = 4'h0; ben[1] = 4'h0;
    xact("wr2", 32'h0000_1008, 4'b0111, 2, 0);
    xact("rd2", 32'h0000_1008, 4'b0110, 2, 0);

    // Byte enables
    dat[0] = 32'h0; ben[0] = 4'h0;
    xact("wr_zero", 32'h0000_1000, 4'b0111, 1, 0);
    dat[0] = 32'h1122_3344; ben[0] = 4'b1010;
    xact("wr_be", 32'h0000_1000, 4'b0111, 1, 0);
    xact("rd_be", 32'h0000_1000, 4'b0110, 1, 0);

    // Window-end disconnect
    fill_rand(1);
    xact("wr_end", 32'h0000_1038, 4'b0111, 4, 0);
    xact("rd_end", 32'h0000_1030, 4'b0110, 6, 20);
    xact("rd_all1", BASE, 4'b0110, 16, 0);

    // Decode misses
    xact("miss_addr", 32'h0000_2000, 4'b0111, 1, 0);
    xact("miss_cmd",  32'h0000_1008, 4'b0010, 1, 0);
    xact("miss_algn", 32'h0000_1009, 4'b0110, 1, 0);

    // Master abort during turnaround
    @(negedge clk);
    frame_n = 1'b0; irdy_n = 1'b1; ad_in = 32'h0000_1004; cbe_n = 4'b0110;
    @(negedge clk);
    chk_bus("abort.turn", 0, 1, 1, 0);
    frame_n = 1'b1; irdy_n = 1'b1;
    @(negedge clk);
    chk_bus("abort.backoff", 1, 1, 1, 0);
    @(negedge clk);
    chk_bus("abort.idle", 1, 1, 1, 0);

    // Heavy master wait states on a read
    xact("rd_wait", 32'h0000_1010, 4'b0110, 4, 60);

    // Randomized traffic
    for (int t = 0; t < 12; t++) begin
      logic [31:0] a;
      logic [3:0]  cm;
      a  = BASE | (32'($urandom_range(15)) << 2);
      cm = ($urandom_range(1) == 1) ? 4'b0111 : 4'b0110;
      fill_rand(0);
      xact("rand", a, cm, $urandom_range(6, 1), 25);
    end

    // Asynchronous reset in the middle of a write burst
    @(negedge clk);
    frame_n = 1'b0; irdy_n = 1'b1; ad_in = BASE; cbe_n = 4'b0111;
    repeat (WS) begin
      @(negedge clk);
      irdy_n = 1'b1;
    end
    @(negedge clk);
    dat[0] = $urandom;
    irdy_n = 1'b0; ad_in = dat[0]; cbe_n = 4'h0;
    ref_mem[0] = dat[0];
    @(negedge clk);
    ad_in = $urandom;
    #2 rst = 1'b1;
    #1;
    chk_bus("rst_mid", 1, 1, 1, 0);
    chk("rst_mid.ad_out", ad_out, 32'h0);
    @(negedge clk);
    rst = 1'b0; frame_n = 1'b1; irdy_n = 1'b1; cbe_n = 4'hF;
    @(negedge clk);
    chk_bus("rst_after", 1, 1, 1, 0);
    xact("rd_all2", BASE, 4'b0110, 16, 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
